// File: rtl/i2c_pkg.sv
// Shared I2C definitions: serializer FSM states, ACK/NACK bus levels and the
// default underrun fill byte.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    MACK,
    STRETCH
  } i2c_ser_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [7:0] I2C_DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_tx_fifo.sv
// Synchronous FIFO holding read words for the I2C slave-transmit serializer.
// A push into a full FIFO is accepted only when a pop happens on the same clock.
module i2c_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     Clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              wr_en;
  logic              rd_en;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign rd_en    = pop & ~empty;
  assign wr_en    = push & (~full | rd_en);
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2c_tx_serializer.sv
// I2C slave-transmit serializer: FIFO-buffered read words shifted MSB-first onto
// SDA on SCL falls, master ACK/NACK sampled on SCL rise. Optional clock
// stretching on underrun is compiled in with I2C_SER_CLK_STRETCH_EN.
module i2c_tx_serializer
  import i2c_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = i2c_pkg::I2C_DEFAULT_FILL_BYTE
) (
  input  logic                          Clock,
  input  logic                          reset,
  input  logic                          i2c_scl,
  input  logic                          i2c_sda,
  output logic                          i2c_sda_out,
  output logic                          i2c_scl_hold,
  input  logic                          start_read,
  input  logic                          stop_in,
  input  logic [DATA_W-1:0]             i2c_rdata,
  input  logic                          i2c_rdata_valid,
  output logic                          i2c_rdata_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          byte_done,
  output logic                          master_nack,
  output logic                          underrun
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev;
  logic                   scl_fall, scl_rise, sda_s;

  i2c_ser_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic [BCW-1:0]    byte_q, byte_d;
  logic              sent_q, sent_d;
  logic              sda_q, sda_d;
  logic              done_d, nack_d, und_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Pins reset to the idle-bus level so no edge is seen when reset releases.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
      scl_prev <= scl_sync[SYNC_STAGES-1];
    end
  end

  assign scl_fall = scl_prev & ~scl_sync[SYNC_STAGES-1];
  assign scl_rise = ~scl_prev & scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];

  assign i2c_rdata_ready = ~fifo_full | fifo_pop;

  i2c_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .reset     (reset),
    .push      (i2c_rdata_valid & i2c_rdata_ready),
    .push_data (i2c_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    sent_d   = sent_q;
    sda_d    = sda_q;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    nack_d   = 1'b0;
    und_d    = 1'b0;
    if (stop_in) begin
      state_d = IDLE;
      shift_d = '0;
      bit_d   = '0;
      byte_d  = '0;
      sent_d  = 1'b0;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_d = 1'b1;
          if (start_read) state_d = LOAD;
        end
        LOAD: begin
          bit_d   = '0;
          byte_d  = '0;
          sent_d  = 1'b0;
          state_d = SHIFT;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
          end else begin
            und_d = 1'b1;
`ifdef I2C_SER_CLK_STRETCH_EN
            state_d = STRETCH;
`else
            shift_d = {NBYTES{FILL_BYTE}};
`endif
          end
        end
        SHIFT: begin
          // sent_q marks that all 8 bits are out; the next fall frees SDA for the ACK.
          if (scl_fall) begin
            if (sent_q) begin
              sda_d   = 1'b1;
              sent_d  = 1'b0;
              state_d = MACK;
            end else begin
              sda_d   = shift_q[DATA_W-1];
              shift_d = {shift_q[DATA_W-2:0], 1'b0};
              bit_d   = bit_q + 3'd1;
              sent_d  = (bit_q == 3'd7);
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              done_d = 1'b1;
              if (byte_q == LAST_BYTE) begin
                byte_d  = '0;
                state_d = LOAD;
              end else begin
                byte_d  = byte_q + 1'b1;
                state_d = SHIFT;
              end
            end else begin
              nack_d  = 1'b1;
              shift_d = '0;
              byte_d  = '0;
              state_d = IDLE;
            end
          end
        end
`ifdef I2C_SER_CLK_STRETCH_EN
        STRETCH: begin
          // SCL is already low under our hold, so the MSB goes out immediately.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sda_d    = fifo_rdata[DATA_W-1];
            shift_d  = {fifo_rdata[DATA_W-2:0], 1'b0};
            bit_d    = 3'd1;
            state_d  = SHIFT;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      sent_q      <= 1'b0;
      sda_q       <= 1'b1;
      byte_done   <= 1'b0;
      master_nack <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      sent_q      <= sent_d;
      sda_q       <= sda_d;
      byte_done   <= done_d;
      master_nack <= nack_d;
      underrun    <= und_d;
    end
  end

  assign i2c_sda_out = sda_q;
  assign busy        = (state_q != IDLE);

`ifdef I2C_SER_CLK_STRETCH_EN
  assign i2c_scl_hold = (state_q == STRETCH);
`else
  assign i2c_scl_hold = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_tx_serializer.sv
// Self-checking bench for i2c_tx_serializer: an 8-bit and a 16-bit instance on a
// shared wired-AND bus, driven by a behavioural I2C master and a queue model.
module tb_i2c_tx_serializer;
  import i2c_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic reset, scl_m, sda_m, stop;
  logic scl_line, sda_line;

  logic       a_sda_out, a_hold, a_start, a_valid, a_ready, a_busy, a_done, a_nack, a_und;
  logic [7:0] a_rdata;
  logic [2:0] a_level;

  logic        b_sda_out, b_hold, b_start, b_valid, b_ready, b_busy, b_done, b_nack, b_und;
  logic [15:0] b_rdata;
  logic [2:0]  b_level;

  assign scl_line = scl_m & ~a_hold & ~b_hold;
  assign sda_line = sda_m & a_sda_out & b_sda_out;

  i2c_tx_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_a (
    .Clock(Clock), .reset(reset), .i2c_scl(scl_line), .i2c_sda(sda_line),
    .i2c_sda_out(a_sda_out), .i2c_scl_hold(a_hold), .start_read(a_start), .stop_in(stop),
    .i2c_rdata(a_rdata), .i2c_rdata_valid(a_valid), .i2c_rdata_ready(a_ready),
    .fifo_level(a_level), .busy(a_busy), .byte_done(a_done), .master_nack(a_nack),
    .underrun(a_und));

  i2c_tx_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_b (
    .Clock(Clock), .reset(reset), .i2c_scl(scl_line), .i2c_sda(sda_line),
    .i2c_sda_out(b_sda_out), .i2c_scl_hold(b_hold), .start_read(b_start), .stop_in(stop),
    .i2c_rdata(b_rdata), .i2c_rdata_valid(b_valid), .i2c_rdata_ready(b_ready),
    .fifo_level(b_level), .busy(b_busy), .byte_done(b_done), .master_nack(b_nack),
    .underrun(b_und));

  int a_done_n = 0, a_nack_n = 0, a_und_n = 0;
  int b_done_n = 0, b_nack_n = 0, b_und_n = 0;
  always @(posedge Clock) begin
    if (a_done) a_done_n <= a_done_n + 1;
    if (a_nack) a_nack_n <= a_nack_n + 1;
    if (a_und)  a_und_n  <= a_und_n + 1;
    if (b_done) b_done_n <= b_done_n + 1;
    if (b_nack) b_nack_n <= b_nack_n + 1;
    if (b_und)  b_und_n  <= b_und_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic push_a(input logic [7:0] d);
    a_rdata = d; a_valid = 1'b1; tick(1); a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] d);
    b_rdata = d; b_valid = 1'b1; tick(1); b_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  // One SCL period: low 12 clocks (master SDA set mid-low), high 12 clocks.
  task automatic bit_clock(input logic m, input bit fall, output logic got, output logic rel);
    if (fall) scl_m = 1'b0;
    tick(6);
    sda_m = m;
    tick(6);
    got = sda_line;
    rel = a_sda_out & b_sda_out;
    scl_m = 1'b1;
    tick(12);
  endtask

  task automatic read_byte(input logic ack, input bit first_fall, output logic [7:0] b,
                           output logic ack_rel);
    logic g, r;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_clock(1'b1, (i > 0) || first_fall, g, r);
      b = {b[6:0], g};
    end
    bit_clock(ack, 1'b1, g, ack_rel);
    sda_m = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic [7:0] exp_byte;
    int         exp_done;
    int         exp_nack;
    int         exp_und;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];
  logic [15:0] q[$];

  initial begin
    logic [7:0]  rb;
    logic        rel;
    int          d0, n0, u0, nbytes, nmax, npush;
    logic [15:0] cur, w;
    logic [7:0]  exp;

    vecs[0] = '{8'hA5, I2C_ACK,  8'hA5, 1, 0, 1, 1'b1};
    vecs[1] = '{8'h00, I2C_NACK, 8'h00, 0, 1, 0, 1'b0};
    vecs[2] = '{8'h5A, I2C_NACK, 8'h5A, 0, 1, 0, 1'b0};
    vecs[3] = '{8'h81, I2C_ACK,  8'h81, 1, 0, 1, 1'b1};
    vecs[4] = '{8'hFE, I2C_NACK, 8'hFE, 0, 1, 0, 1'b0};

    reset = 1'b0; stop = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    a_start = 1'b0; a_valid = 1'b0; a_rdata = '0;
    b_start = 1'b0; b_valid = 1'b0; b_rdata = '0;
    tick(3);
    check("rst_sda",   {31'd0, a_sda_out}, 32'd1);
    check("rst_hold",  {31'd0, a_hold},    32'd0);
    check("rst_busy",  {31'd0, a_busy | b_busy}, 32'd0);
    check("rst_level", {29'd0, a_level},   32'd0);
    check("rst_ready", {31'd0, a_ready & b_ready}, 32'd1);
    check("rst_pulse", {29'd0, a_done, a_nack, a_und}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Single-byte vectors on the 8-bit instance.
    for (int i = 0; i < 5; i++) begin
      push_a(vecs[i].data);
      d0 = a_done_n; n0 = a_nack_n; u0 = a_und_n;
      a_start = 1'b1; tick(1); a_start = 1'b0;
      read_byte(vecs[i].ack, 1'b1, rb, rel);
      tick(2);
      check($sformatf("vec%0d_byte", i), {24'd0, rb}, {24'd0, vecs[i].exp_byte});
      check($sformatf("vec%0d_rel", i),  {31'd0, rel}, 32'd1);
      check($sformatf("vec%0d_done", i), a_done_n - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_nack", i), a_nack_n - n0, vecs[i].exp_nack);
      check($sformatf("vec%0d_und", i),  a_und_n - u0,  vecs[i].exp_und);
      check($sformatf("vec%0d_busy", i), {31'd0, a_busy}, {31'd0, vecs[i].exp_busy});
      if (vecs[i].exp_busy) pulse_stop();
      tick(2);
    end

    // 16-bit word, both bytes ACKed.
    push_b(16'h3C81);
    tick(1);
    check("w16_level_before", {29'd0, b_level}, 32'd1);
    d0 = b_done_n;
    b_start = 1'b1; tick(1); b_start = 1'b0;
    read_byte(I2C_ACK, 1'b1, rb, rel);
    check("w16_byte0", {24'd0, rb}, 32'h3C);
    check("w16_level_after", {29'd0, b_level}, 32'd0);
    read_byte(I2C_ACK, 1'b1, rb, rel);
    check("w16_byte1", {24'd0, rb}, 32'h81);
    tick(2);
    check("w16_done", b_done_n - d0, 32'd2);
    pulse_stop();
    tick(2);

    // NACK on the first byte discards the rest of the word.
    push_b(16'hFFFF);
    d0 = b_done_n; n0 = b_nack_n;
    b_start = 1'b1; tick(1); b_start = 1'b0;
    read_byte(I2C_NACK, 1'b1, rb, rel);
    tick(2);
    check("nack_byte", {24'd0, rb}, 32'hFF);
    check("nack_count", b_nack_n - n0, 32'd1);
    check("nack_busy", {31'd0, b_busy}, 32'd0);
    read_byte(I2C_ACK, 1'b1, rb, rel);
    check("nack_idle_sda", {24'd0, rb}, 32'hFF);
    check("nack_no_done", b_done_n - d0, 32'd0);
    check("nack_still_idle", {31'd0, b_busy}, 32'd0);

`ifdef I2C_SER_CLK_STRETCH_EN
    // Underrun with stretching: SCL held until a word arrives.
    u0 = a_und_n;
    a_start = 1'b1; tick(1); a_start = 1'b0;
    tick(4);
    check("str_hold_on", {31'd0, a_hold}, 32'd1);
    check("str_und", a_und_n - u0, 32'd1);
    scl_m = 1'b0;
    tick(8);
    push_a(8'h55);
    check("str_hold_push", {31'd0, a_hold}, 32'd1);
    tick(1);
    check("str_hold_off", {31'd0, a_hold}, 32'd0);
    read_byte(I2C_NACK, 1'b0, rb, rel);
    tick(2);
    check("str_byte", {24'd0, rb}, 32'h55);
    check("str_und_once", a_und_n - u0, 32'd1);
`else
    // Underrun without stretching: fill byte goes out.
    u0 = a_und_n;
    a_start = 1'b1; tick(1); a_start = 1'b0;
    read_byte(I2C_NACK, 1'b1, rb, rel);
    tick(2);
    check("und_byte", {24'd0, rb}, 32'hFF);
    check("und_count", a_und_n - u0, 32'd1);
    check("und_hold", {31'd0, a_hold}, 32'd0);
`endif
    tick(2);

    // Randomised bursts on the 16-bit instance against a word-queue model.
    for (int it = 0; it < 8; it++) begin
      npush = $urandom_range(1, 5);
      for (int k = 0; k < npush; k++) begin
        w = 16'($urandom);
        check("rnd_ready", {31'd0, b_ready}, {31'd0, (q.size() < 4)});
        push_b(w);
        if (q.size() < 4) q.push_back(w);
        check("rnd_level", {29'd0, b_level}, q.size());
      end
      nmax = q.size() * 2;
      if (nmax > 5) nmax = 5;
      nbytes = $urandom_range(1, nmax);
      d0 = b_done_n; n0 = b_nack_n; u0 = b_und_n;
      cur = '0;
      b_start = 1'b1; tick(1); b_start = 1'b0;
      for (int j = 0; j < nbytes; j++) begin
        if (j % 2 == 0) begin
          cur = q.pop_front();
          exp = cur[15:8];
        end else begin
          exp = cur[7:0];
        end
        read_byte((j == nbytes - 1) ? I2C_NACK : I2C_ACK, 1'b1, rb, rel);
        check($sformatf("rnd%0d_byte%0d", it, j), {24'd0, rb}, {24'd0, exp});
      end
      tick(2);
      check("rnd_done", b_done_n - d0, nbytes - 1);
      check("rnd_nack", b_nack_n - n0, 32'd1);
      check("rnd_und",  b_und_n - u0,  32'd0);
      check("rnd_busy", {31'd0, b_busy}, 32'd0);
      check("rnd_level_end", {29'd0, b_level}, q.size());
    end

    // stop_in mid-byte on the 8-bit instance.
    push_a(8'h00);
    push_a(8'h11);
    a_start = 1'b1; tick(1); a_start = 1'b0;
    for (int i = 0; i < 4; i++) bit_clock(1'b1, 1'b1, rb[0], rel);
    check("stop_pre_sda", {31'd0, a_sda_out}, 32'd0);
    pulse_stop();
    check("stop_sda", {31'd0, a_sda_out}, 32'd1);
    check("stop_busy", {31'd0, a_busy}, 32'd0);
    check("stop_level", {29'd0, a_level}, 32'd1);

    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    check("rst2_level", {29'd0, a_level}, 32'd0);

    // Overflow: fifth push dropped.
    for (int i = 0; i < 5; i++) push_a(8'(8'h10 + i));
    check("ovf_ready", {31'd0, a_ready}, 32'd0);
    check("ovf_level", {29'd0, a_level}, 32'd4);

    reset = 1'b0; tick(1);
    check("rst3_sda",   {31'd0, a_sda_out}, 32'd1);
    check("rst3_hold",  {31'd0, a_hold},    32'd0);
    check("rst3_busy",  {31'd0, a_busy},    32'd0);
    check("rst3_level", {29'd0, a_level},   32'd0);
    check("rst3_ready", {31'd0, a_ready},   32'd1);
    check("rst3_pulse", {29'd0, a_done, a_nack, a_und}, 32'd0);
    reset = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_tx_serializer.md
# i2c_tx_serializer

Parametrised slave-transmit serializer for the I2C slave. Buffers read data in a small FIFO, shifts it MSB-first onto SDA on SCL falling edges, and samples the master's ACK/NACK after every byte. Multi-byte words and continuous read bursts need no per-byte intervention from the register file. Sits between the address/ACK control logic (`start_read`, `stop_in`) and the open-drain SDA pad driver.

## Interface
- `DATA_W`, 8: width of one read word; multiple of 8; transmitted most-significant byte first.
- `FIFO_DEPTH`, 4: words buffered; power of 2, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops on `i2c_scl` and `i2c_sda`; ≥2.
- `FILL_BYTE`, 8'hFF: byte sent on underrun (non-stretch build).

Ports:
- `Clock` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low; clears all state.
- `i2c_scl` in 1: raw SCL pin.
- `i2c_sda` in 1: raw SDA pin.
- `i2c_sda_out` out 1: 1 releases SDA, 0 pulls it low.
- `i2c_scl_hold` out 1: 1 holds SCL low (clock stretch); tied 0 unless stretching is compiled in.
- `start_read` in 1: one-cycle pulse, address phase with R/W=1 ACKed by slave.
- `stop_in` in 1: one-cycle pulse, STOP/repeated START detected upstream.
- `i2c_rdata` in DATA_W: read word to push.
- `i2c_rdata_valid` in 1: push request.
- `i2c_rdata_ready` out 1: FIFO not full; push occurs when valid & ready.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: words held.
- `busy` out 1: state ≠ IDLE.
- `byte_done` out 1: pulse, master ACKed a byte.
- `master_nack` out 1: pulse, master NACKed.
- `underrun` out 1: pulse, byte boundary reached with FIFO empty.

## Operation
- Reset values: `i2c_sda_out`=1, `i2c_scl_hold`=0, `busy`=0, all pulses 0, FIFO empty (`fifo_level`=0, `i2c_rdata_ready`=1), bit and byte counters 0.
- States:
  - IDLE: `start_read` → LOAD.
  - LOAD: pop a word into the shift register if the FIFO is non-empty; otherwise handle per Configuration. → SHIFT.
  - SHIFT: on each SCL fall, drive the next bit. After the 8th bit of a byte, the following SCL fall releases SDA → MACK.
  - MACK: sample SDA on the SCL rise.
    - 0 (ACK): pulse `byte_done`. If more bytes remain in the word, stay in SHIFT and continue with the next byte; otherwise → LOAD.
    - 1 (NACK): pulse `master_nack`, release SDA → IDLE; the unsent remainder of the word is discarded.
- `stop_in` or `reset` in any state: → IDLE, SDA released, shift register cleared. FIFO contents survive `stop_in`; `reset` clears them.
- `start_read` while busy is ignored.
- Simultaneous push and pop with the FIFO full is allowed and the level is unchanged. A push attempted while full is dropped.
- Simultaneous `stop_in` and a SCL edge: `stop_in` wins.
- Bit counter is 3 bits and wraps 7→0 per byte. Byte counter runs to DATA_W/8−1.

## Timing
- Synchronised SCL edges are detected SYNC_STAGES+1 clocks after the pin changes.
- `i2c_sda_out` updates on the clock after a detected SCL fall. SCL low time must be ≥ SYNC_STAGES+3 Clock periods.
- First MSB is driven on the first SCL fall after `start_read`. `start_read` must arrive before the fall that ends the address ACK clock.
- ACK is sampled on the clock where the synchronised SCL rise is detected.
- `i2c_rdata_ready` and `fifo_level` reflect a push on the next clock.

## Configuration
- Macro: `I2C_SER_CLK_STRETCH_EN`.
- Defined: on LOAD with the FIFO empty, assert `i2c_scl_hold`, pulse `underrun` once, and wait in an added STRETCH state. The first push releases the hold one clock later → SHIFT.
- Not defined: on LOAD with the FIFO empty, load FILL_BYTE repeated to DATA_W, pulse `underrun`, continue to SHIFT. `i2c_scl_hold` is constant 0 and the STRETCH state does not exist.

## Structure
- Shared package `i2c_pkg`:
  - `i2c_ser_state_t` enum: IDLE, LOAD, SHIFT, MACK, STRETCH.
  - `I2C_ACK`=1'b0, `I2C_NACK`=1'b1.
  - Default `FILL_BYTE`.
- One sub-module: `i2c_tx_fifo` (synchronous FIFO, DATA_W × FIFO_DEPTH, with level output). Synchroniser, edge detect and FSM stay in the top.

## Test plan
- DATA_W=8. Push 8'hA5, `start_read`, then 9 SCL clocks with master ACK → SDA bits 1,0,1,0,0,1,0,1, released on the 9th clock, one `byte_done` pulse.
- DATA_W=16. Push 16'h3C81, master ACKs both bytes → 8'h3C then 8'h81 appear on SDA, two `byte_done` pulses, `fifo_level` 1→0.
- Master NACKs the first byte of 16'hFFFF → one `master_nack` pulse, SDA stays released, FSM returns to IDLE, the second byte is never driven.
- FIFO empty at LOAD, non-stretch build → 8'hFF sent, one `underrun` pulse. Stretch build → `i2c_scl_hold`=1 until a push of 8'h55, released one clock later, then 8'h55 is shifted.
- `stop_in` pulsed mid-byte (after bit 4) → SDA released within 1 clock, `busy`=0, FIFO level unchanged.
- Push 5 words with FIFO_DEPTH=4 → the 5th push is dropped, `i2c_rdata_ready`=0, `fifo_level`=4. Assert `reset`=0 for 1 clock → all outputs return to their reset values.
